btn_event: RTL and testbench

Button event classifier that sits directly downstream of the debouncing FSM. It consumes the debounced level `db_in` and turns it into single-cycle event pulses: press, release, short press, long press and auto-repeat. It also provides a held level and a wrapping press counter for the user-interface logic.

---
 rtl/btn_event.sv | 108 ++++++++++
 tb/tb_btn_event.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/btn_event.sv
// Button event classifier: turns a debounced level into press/release/short/long/repeat
// pulses plus a held level and a wrapping press counter. All outputs are registered.
module btn_event #(
    parameter int unsigned LONG_TICKS   = 50_000_000,
    parameter int unsigned REPEAT_TICKS = 10_000_000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       db_in_i,
    output logic       press_o,
    output logic       release_o,
    output logic       short_press_o,
    output logic       long_press_o,
    output logic       repeat_tick_o,
    output logic       held_o,
    output logic [7:0] press_count_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             db_prev_q;
    logic             press_q, release_q, short_q, long_q, repeat_q, held_q;
    logic [7:0]       count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            // Seeded high so a button held through reset is not seen as a new press.
            db_prev_q <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            db_prev_q <= db_in_i;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (db_in_i && !db_prev_q) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                        count_q <= count_q + 8'd1;
                    end
                end
                PRESSED: begin
                    // Release is tested first so it wins over a coincident long threshold.
                    if (!db_in_i) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        short_q   <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q <= LONG;
                        long_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (!db_in_i) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt_q == REPEAT_LAST) begin
                        repeat_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign press_o       = press_q;
    assign release_o     = release_q;
    assign short_press_o = short_q;
    assign long_press_o  = long_q;
    assign repeat_tick_o = repeat_q;
    assign held_o        = held_q;
    assign press_count_o = count_q;

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: per-cycle comparison against a hold-length model, plus
// directed literal checks on latencies, event priorities, counter wrap and reset.
module tb_btn_event;

    localparam int L = 8;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       db_in = 1'b1;
    logic       press_o, release_o, short_press_o, long_press_o, repeat_tick_o, held_o;
    logic [7:0] press_count_o;

    btn_event #(.LONG_TICKS(L), .REPEAT_TICKS(R), .CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .db_in_i       (db_in),
        .press_o       (press_o),
        .release_o     (release_o),
        .short_press_o (short_press_o),
        .long_press_o  (long_press_o),
        .repeat_tick_o (repeat_tick_o),
        .held_o        (held_o),
        .press_count_o (press_count_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model state: whether the button is held, and how many edges since the accepted press.
    bit m_held = 0, m_prev = 1;
    int m_j = 0;
    int m_cnt = 0;
    bit e_press, e_rel, e_short, e_long, e_rep;
    int cyc = 0;
    int t_press = -1, t_long = -1, t_rep1 = -1, rep_n = 0, n_press = 0;

    always @(posedge clk) begin
        cyc++;
        e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_rep = 0;
        if (reset) begin
            m_held = 0; m_prev = 1; m_cnt = 0; m_j = 0;
        end else begin
            if (!m_held) begin
                if (db_in && !m_prev) begin
                    e_press = 1; m_held = 1; m_j = 0; m_cnt = (m_cnt + 1) % 256;
                end
            end else begin
                m_j++;
                if (!db_in) begin
                    e_rel = 1; e_short = (m_j <= L); m_held = 0;
                end else begin
                    e_long = (m_j == L);
                    e_rep  = (m_j > L) && ((m_j - L) % R == 0);
                end
            end
            m_prev = db_in;
        end
        #2;
        chk("press", press_o, e_press);
        chk("release", release_o, e_rel);
        chk("short_press", short_press_o, e_short);
        chk("long_press", long_press_o, e_long);
        chk("repeat_tick", repeat_tick_o, e_rep);
        chk("held", held_o, m_held);
        chk("press_count", press_count_o, m_cnt);
        if (press_o) begin t_press = cyc; t_long = -1; rep_n = 0; n_press++; end
        if (long_press_o) t_long = cyc;
        if (repeat_tick_o) begin if (rep_n == 0) t_rep1 = cyc; rep_n++; end
    end

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int np;
        // Reset with the button held, then keep holding: nothing may happen.
        nedge(3);
        reset = 1'b0;
        nedge(20);
        chk("held_through_reset held", held_o, 0);
        chk("held_through_reset count", press_count_o, 0);
        chk("held_through_reset presses", n_press, 0);

        // Drop for 2 cycles, raise: press one cycle after the rise edge.
        db_in = 1'b0; nedge(2);
        db_in = 1'b1; nedge(1);
        chk("first press", press_o, 1);
        chk("first count", press_count_o, 1);
        chk("first held", held_o, 1);

        // Keep holding to 20 cycles after press: long at +8, repeats every 4.
        nedge(20);
        chk("long latency", t_long - t_press, 8);
        chk("repeat1 latency", t_rep1 - t_long, 4);
        chk("repeat count", rep_n, 3);
        db_in = 1'b0; nedge(1);
        chk("long release", release_o, 1);
        chk("long release short", short_press_o, 0);
        chk("long release held", held_o, 0);
        nedge(2);

        // Short press: held 5 cycles.
        db_in = 1'b1; nedge(5);
        db_in = 1'b0; nedge(1);
        chk("short release", release_o, 1);
        chk("short short_press", short_press_o, 1);
        chk("short no long", t_long, -1);
        nedge(2);

        // Release on the edge where cnt = 7 in PRESSED: release wins.
        db_in = 1'b1; nedge(8);
        db_in = 1'b0; nedge(1);
        chk("edge7 release", release_o, 1);
        chk("edge7 short", short_press_o, 1);
        chk("edge7 long", long_press_o, 0);
        chk("edge7 no long seen", t_long, -1);
        nedge(2);

        // Release on the edge where cnt = 3 in LONG: no repeat.
        db_in = 1'b1; nedge(12);
        db_in = 1'b0; nedge(1);
        chk("long3 release", release_o, 1);
        chk("long3 repeat", repeat_tick_o, 0);
        chk("long3 short", short_press_o, 0);
        chk("long3 repeats seen", rep_n, 0);
        nedge(2);

        // 256 back-to-back minimum-spacing presses from a fresh reset.
        reset = 1'b1; nedge(2);
        reset = 1'b0; nedge(1);
        for (int i = 0; i < 256; i++) begin
            db_in = 1'b1; nedge(1);
            if (i == 254) chk("count 255", press_count_o, 255);
            if (i == 255) begin
                chk("count wrap", press_count_o, 0);
                chk("wrap press", press_o, 1);
            end
            db_in = 1'b0; nedge(1);
        end
        nedge(2);

        // Reset mid-LONG with the button still held.
        db_in = 1'b1; nedge(12);
        chk("midlong held", held_o, 1);
        reset = 1'b1; nedge(1);
        chk("midreset held", held_o, 0);
        chk("midreset release", release_o, 0);
        chk("midreset count", press_count_o, 0);
        reset = 1'b0;
        np = n_press;
        nedge(5);
        chk("no press while held", n_press, np);
        db_in = 1'b0; nedge(1);
        chk("no release after reset", release_o, 0);
        db_in = 1'b1; nedge(1);
        chk("repress press", press_o, 1);
        chk("repress count", press_count_o, 1);
        db_in = 1'b0; nedge(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
